morse_symbol_packer: RTL
========================

// Module: morse_symbol_packer
// PURPOSE
//  Fully synchronous, parametrised successor of the Morse dot/dash shifter. Packs
//  classified symbols (dot, dash, char-space, word-space) from the timing detector into
//  sentinel-prefixed codes and queues them in an output FIFO with a valid/ready handshake.
//  It sits between the symbol classifier and the code-to-ASCII decoder. It adds overflow
//  detection, word-end tagging and backpressure.
// PARAMETERS
//  MAX_SYM     7  max dots/dashes per character; code width CW = MAX_SYM+1 (sentinel bit)
//  FIFO_DEPTH  4  output queue entries, power of two, >=2
// PORTS
//  clk          in   1      clock, all logic on posedge
//  reset        in   1      synchronous, active-high
//  sym_valid    in   1      qualifies the symbol inputs for this cycle
//  sym_dot      in   1      dot symbol
//  sym_dash     in   1      dash symbol
//  sym_chs      in   1      inter-character gap
//  sym_ws       in   1      inter-word gap
//  out_valid    out  1      FIFO head valid
//  out_ready    in   1      consumer accepts head
//  out_code     out  CW     sentinel-prefixed code; 1 followed by symbols, MSB-first, dash=1
//  out_word_end out  1      head entry terminates a word
//  out_err      out  1      head character overflowed MAX_SYM symbols
//  fifo_count   out  $clog2(FIFO_DEPTH)+1  occupied entries
//  drop         out  1      one-cycle pulse: completed entry lost, FIFO full
// BEHAVIOUR
//  Reset: acc=1, nsym=0, err=0, FIFO empty. Outputs out_valid=0, out_code=0,
//   out_word_end=0, out_err=0, fifo_count=0, drop=0. Reset mid-character discards acc.
//  Symbols are sampled only when sym_valid=1. Priority is ws > chs > dash > dot.
//   Lower-priority bits set in the same cycle are ignored.
//  dot/dash with nsym<MAX_SYM: acc<={acc[CW-2:0],dash}, nsym++.
//  dot/dash with nsym==MAX_SYM: acc unchanged, err<=1 (sticky until a boundary).
//  chs with nsym==0: no action.
//  chs with nsym>0: push {acc,word_end=0,err}.
//  ws with nsym>0: push {acc,1,err}.
//  ws with nsym==0: push {code=1,word_end=1,err=0}, a standalone space marker.
//  After any push attempt: acc<=1, nsym<=0, err<=0, whether or not the push was accepted.
//  Push when full and no pop in that cycle: entry discarded, drop=1 for one cycle.
//   fifo_count does not change.
//  Push and pop in the same cycle when full: the push is accepted.
//  Handshake: out_valid = (fifo_count!=0). A pop occurs iff out_valid&&out_ready.
//   The head is stable while out_valid&&!out_ready.
//  Latency: boundary sampled in cycle N with the FIFO empty -> out_valid=1 in cycle N+1.
//  When out_valid=0, out_code/out_word_end/out_err read 0.
//  Pointers wrap modulo FIFO_DEPTH. fifo_count ranges 0..FIFO_DEPTH.
// STRUCTURE
//  morse_pkg: SENTINEL constant (CW'd1), entry typedef {code, word_end, err}, and
//   symbol-priority encode function.
//  Sub-module morse_sync_fifo: generic WIDTH/DEPTH FIFO with push/pop, full/empty
//   and count.
//  Top level holds the accumulator, nsym counter, err flag and push/drop logic.
// TESTING
//  - Dot,dash,dot then chs -> out_code=8'b0000_1010, word_end=0, err=0 one cycle later.
//  - Dash x3, ws, then ws with no symbols -> entry 0x0F with word_end=1,
//    then entry 0x01 with word_end=1.
//  - 8 dots with MAX_SYM=7, then chs -> code=8'h80, err=1. The next character
//    has err=0.
//  - out_ready=0 and 5 characters with FIFO_DEPTH=4 -> fifo_count=4, drop pulses once.
//    Draining yields the first 4 in order.
//  - FIFO full with out_ready=1 and a push in the same cycle -> no drop, fifo_count stays 4.
//  - Reset asserted after 2 dashes, then dot, chs -> code=8'b10, FIFO empty after
//    reset, no stale entry.

Source files
------------

// File: rtl/morse_pkg.sv
// rtl/morse_pkg.sv - shared constants, entry layout and symbol priority encoder
// Purpose: common definitions for the Morse symbol packer.
//   SENTINEL    : leading 1 that marks the start of every packed code
//   sym_kind_e  : one decoded symbol per cycle after priority resolution
//   entry_t     : queue entry layout {code, word_end, err} for the default width
//   sym_encode  : resolves simultaneous symbol bits, ws > chs > dash > dot
package morse_pkg;

   localparam int MAX_SYM_DEF = 7;
   localparam int CW_DEF      = MAX_SYM_DEF + 1;

   localparam logic [CW_DEF-1:0] SENTINEL = CW_DEF'(1);

   typedef enum logic [2:0] {
      SYM_NONE = 3'd0,
      SYM_DOT  = 3'd1,
      SYM_DASH = 3'd2,
      SYM_CHS  = 3'd3,
      SYM_WS   = 3'd4
   } sym_kind_e;

   typedef struct packed {
      logic [CW_DEF-1:0] code;
      logic              word_end;
      logic              err;
   } entry_t;

   function automatic sym_kind_e sym_encode(
      input logic i_valid,
      input logic i_ws,
      input logic i_chs,
      input logic i_dash,
      input logic i_dot
   );
      sym_kind_e kind;
      kind = SYM_NONE;
      if (i_valid) begin
         if (i_ws)        kind = SYM_WS;
         else if (i_chs)  kind = SYM_CHS;
         else if (i_dash) kind = SYM_DASH;
         else if (i_dot)  kind = SYM_DOT;
      end
      return kind;
   endfunction

endpackage

// File: rtl/morse_sync_fifo.sv
// rtl/morse_sync_fifo.sv - generic synchronous FIFO with occupancy count
// Purpose: single-clock queue; a push while full is accepted only if a pop
//   happens in the same cycle, otherwise it is ignored.
// Ports:
//   clk, reset  : clock, synchronous active-high reset
//   i_push      : write request, i_wdata written when accepted
//   i_pop       : read request, ignored while empty
//   o_rdata     : head entry (raw memory contents, caller masks when empty)
//   o_full      : count == DEPTH
//   o_empty     : count == 0
//   o_count     : occupied entries, 0..DEPTH
module morse_sync_fifo #(
   parameter int WIDTH = 10,
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     i_push,
   input  logic [WIDTH-1:0]         i_wdata,
   input  logic                     i_pop,
   output logic [WIDTH-1:0]         o_rdata,
   output logic                     o_full,
   output logic                     o_empty,
   output logic [$clog2(DEPTH):0]   o_count
);

   localparam int PW = $clog2(DEPTH);
   localparam logic [PW:0] FULL_CNT = (PW+1)'(DEPTH);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [PW-1:0]    r_wr_ptr;
   logic [PW-1:0]    r_rd_ptr;
   logic [PW:0]      r_count;
   logic             w_wr_en;
   logic             w_rd_en;

   assign o_full  = (r_count == FULL_CNT);
   assign o_empty = (r_count == '0);
   assign o_count = r_count;
   assign o_rdata = r_mem[r_rd_ptr];

   assign w_rd_en = i_pop && !o_empty;
   // A full queue still takes a write when the head leaves in the same cycle.
   assign w_wr_en = i_push && (!o_full || w_rd_en);

   always_ff @(posedge clk) begin
      if (w_wr_en) begin
         r_mem[r_wr_ptr] <= i_wdata;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_wr_en) r_wr_ptr <= r_wr_ptr + PW'(1);
         if (w_rd_en) r_rd_ptr <= r_rd_ptr + PW'(1);
         case ({w_wr_en, w_rd_en})
            2'b10:   r_count <= r_count + (PW+1)'(1);
            2'b01:   r_count <= r_count - (PW+1)'(1);
            default: r_count <= r_count;
         endcase
      end
   end

endmodule

// File: rtl/morse_symbol_packer.sv
// rtl/morse_symbol_packer.sv - packs Morse symbols into sentinel-prefixed codes and queues them
// Purpose: accumulates dots/dashes of one character, emits {code, word_end, err}
//   at character/word gaps into an output FIFO with valid/ready handshake.
// Ports:
//   clk, reset                         : clock, synchronous active-high reset
//   sym_valid, sym_dot, sym_dash,
//   sym_chs, sym_ws                    : classified symbol input, ws > chs > dash > dot
//   out_valid, out_ready               : head handshake, pop when both high
//   out_code                           : 1 followed by symbols MSB-first, dash=1
//   out_word_end                       : head entry ends a word
//   out_err                            : head character exceeded MAX_SYM symbols
//   fifo_count                         : occupied queue entries
//   drop                               : one-cycle pulse when a completed entry was lost
module morse_symbol_packer
   import morse_pkg::*;
#(
   parameter int MAX_SYM    = 7,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic                          sym_valid,
   input  logic                          sym_dot,
   input  logic                          sym_dash,
   input  logic                          sym_chs,
   input  logic                          sym_ws,
   output logic                          out_valid,
   input  logic                          out_ready,
   output logic [MAX_SYM:0]              out_code,
   output logic                          out_word_end,
   output logic                          out_err,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
   output logic                          drop
);

   localparam int CW   = MAX_SYM + 1;
   localparam int NSW  = $clog2(MAX_SYM + 1);
   localparam int EW   = CW + 2;
   localparam int CNTW = $clog2(FIFO_DEPTH) + 1;
   localparam logic [CW-1:0]  SENT_CODE = CW'(SENTINEL);
   localparam logic [NSW-1:0] NSYM_MAX  = NSW'(MAX_SYM);

   sym_kind_e        w_kind;
   logic [CW-1:0]    r_acc;
   logic [NSW-1:0]   r_nsym;
   logic             r_err;
   logic             r_drop;
   logic             w_push;
   logic [EW-1:0]    w_push_entry;
   logic             w_boundary;
   logic             w_pop;
   logic             w_full;
   logic             w_empty;
   logic [EW-1:0]    w_head;
   logic [CNTW-1:0]  w_count;

   assign w_kind     = sym_encode(sym_valid, sym_ws, sym_chs, sym_dash, sym_dot);
   assign w_boundary = (w_kind == SYM_CHS) || (w_kind == SYM_WS);

   // A word gap always produces an entry; with no pending symbols it becomes a
   // bare space marker so the decoder still sees the word break.
   always_comb begin
      w_push       = 1'b0;
      w_push_entry = {SENT_CODE, 1'b0, 1'b0};
      case (w_kind)
         SYM_CHS: begin
            if (r_nsym != '0) begin
               w_push       = 1'b1;
               w_push_entry = {r_acc, 1'b0, r_err};
            end
         end
         SYM_WS: begin
            w_push = 1'b1;
            if (r_nsym != '0) w_push_entry = {r_acc, 1'b1, r_err};
            else              w_push_entry = {SENT_CODE, 1'b1, 1'b0};
         end
         default: ;
      endcase
   end

   // Accumulator restarts at every boundary even if the FIFO refused the entry.
   always_ff @(posedge clk) begin
      if (reset || w_boundary) begin
         r_acc  <= SENT_CODE;
         r_nsym <= '0;
         r_err  <= 1'b0;
      end else if ((w_kind == SYM_DOT) || (w_kind == SYM_DASH)) begin
         if (r_nsym < NSYM_MAX) begin
            r_acc  <= {r_acc[CW-2:0], (w_kind == SYM_DASH)};
            r_nsym <= r_nsym + NSW'(1);
         end else begin
            r_err  <= 1'b1;
         end
      end
   end

   assign w_pop = !w_empty && out_ready;

   always_ff @(posedge clk) begin
      if (reset) r_drop <= 1'b0;
      else       r_drop <= w_push && w_full && !w_pop;
   end

   morse_sync_fifo #(
      .WIDTH (EW),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk     (clk),
      .reset   (reset),
      .i_push  (w_push),
      .i_wdata (w_push_entry),
      .i_pop   (w_pop),
      .o_rdata (w_head),
      .o_full  (w_full),
      .o_empty (w_empty),
      .o_count (w_count)
   );

   assign out_valid  = !w_empty;
   assign fifo_count = w_count;
   assign drop       = r_drop;
   assign {out_code, out_word_end, out_err} = out_valid ? w_head : '0;

endmodule
